// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds
// and sticky error flags. Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads.
module param_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned AFULL_TH  = (1 << ADDR_BITS) - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [WIDTH-1:0]     din,
    input  logic                 re,
    output logic [WIDTH-1:0]     dout,
    output logic                 dvalid,
    output logic                 empty,
    output logic                 full,
    output logic                 afull,
    output logic                 aempty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CW    = ADDR_BITS + 1;
    localparam logic [ADDR_BITS:0] DEPTH_CNT  = CW'(DEPTH);
    localparam logic               AFULL_RST  = (AFULL_TH == 0);
    localparam logic               AEMPTY_RST = 1'b1;

    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 afull_q, afull_d;
    logic                 aempty_q, aempty_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic                 wr_ok;
    logic                 rd_ok;

    // Acceptance uses only registered status, so no we/re path reaches any output.
    always_comb begin
        wr_ok = we & ~full_q;
        rd_ok = re & ~empty_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Status flags are registered from the next-cycle count so they track count exactly.
    always_comb begin
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_CNT);
        afull_d  = (32'(count_d) >= AFULL_TH);
        aempty_d = (32'(count_d) <= AEMPTY_TH);
    end

    // A new error outranks a simultaneous clear.
    always_comb begin
        overflow_d  = (overflow_q  & ~clr_err) | (we & full_q);
        underflow_d = (underflow_q & ~clr_err) | (re & empty_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            afull_q     <= AFULL_RST;
            aempty_q    <= AEMPTY_RST;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; after a reset the pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // Head word is shown straight from storage; dvalid simply mirrors non-empty.
    always_comb begin
        dout   = mem_q[rd_ptr_q];
        dvalid = ~empty_q;
    end
`else
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;

    always_comb begin
        dout_d   = dout_q;
        dvalid_d = rd_ok;
        if (rd_ok) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    always_comb begin
        dout   = dout_q;
        dvalid = dvalid_q;
    end
`endif

    always_comb begin
        empty     = empty_q;
        full      = full_q;
        afull     = afull_q;
        aempty    = aempty_q;
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule
